// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding and
// the default sequential step / fault instruction used by instr_fetch.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP,
    ST_OUT
  } fetch_state_e;

  localparam int unsigned DEFAULT_PC_STEP   = 4;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// hands the fetched word to decode, and owns PC advance and redirect handling.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned PC_STEP   = DEFAULT_PC_STEP,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic         if_fault_q, if_fault_d;
  logic [31:0]  pc_inc;
  logic         pc_misaligned;

  // 32-bit add wraps naturally, so the last word of the address space steps to 0.
  assign pc_inc        = if_pc_q + 32'(PC_STEP);
  assign pc_misaligned = |pc[1:0];

  // NOTE: every signal driven here gets a default before the case statement so
  // no path leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d        = state_q;
    if_instr_d     = if_instr_q;
    if_pc_d        = if_pc_q;
    if_fault_d     = if_fault_q;
    pc_write       = 1'b0;
    pc_next        = '0;
    imem_req_valid = 1'b0;
    imem_req_addr  = '0;
    if_valid       = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        imem_req_addr = pc;
        if (!redirect_valid) begin
          if (pc_misaligned) begin
            if_pc_d    = pc;
            if_instr_d = NOP_INSTR;
            if_fault_d = 1'b1;
            state_d    = ST_OUT;
          end else begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
              if_pc_d = pc;
              state_d = ST_WAIT;
            end
          end
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          // A response landing with the redirect is simply dropped here.
          state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          if_instr_d = imem_rsp_data;
          pc_write   = 1'b1;
          pc_next    = pc_inc;
          state_d    = ST_OUT;
        end
      end

      ST_DROP: begin
        if (imem_rsp_valid) state_d = ST_REQ;
      end

      ST_OUT: begin
        if (redirect_valid) begin
          if_fault_d = 1'b0;
          state_d    = ST_REQ;
        end else begin
          if_valid = 1'b1;
          if (if_ready) begin
            if_fault_d = 1'b0;
            state_d    = ST_REQ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Redirect outranks the sequential advance as the PC source.
    if (redirect_valid && (state_q != ST_IDLE)) begin
      pc_write = 1'b1;
      pc_next  = redirect_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_fault_q <= if_fault_d;
    end
  end

  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_fault = if_fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a directed cycle table, hand-written
// redirect/reset sequences, then randomized traffic against a fetch-stream model.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic        L   = 1'b0;
  localparam logic        H   = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  always #5 clk = ~clk;

  instr_fetch #(.PC_STEP(4), .NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_write        (pc_write),
    .pc_next         (pc_next),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_fault        (if_fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        redir;
    logic [31:0] tgt;
    logic        ifr;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_pw;
    logic [31:0] e_pn;
    logic        e_ifv;
    logic [31:0] e_ifpc;
    logic [31:0] e_instr;
    logic        e_fault;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] p, input logic rdy, input logic rspv, input logic [31:0] rspd,
    input logic redir, input logic [31:0] tgt, input logic ifr,
    input logic e_reqv, input logic [31:0] e_addr, input logic e_pw, input logic [31:0] e_pn,
    input logic e_ifv, input logic [31:0] e_ifpc, input logic [31:0] e_instr, input logic e_fault);
    vec_t v;
    v.pc = p; v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.redir = redir; v.tgt = tgt;
    v.ifr = ifr; v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_pw = e_pw; v.e_pn = e_pn;
    v.e_ifv = e_ifv; v.e_ifpc = e_ifpc; v.e_instr = e_instr; v.e_fault = e_fault;
    return v;
  endfunction

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F0F};
  endfunction

  task automatic drive(input logic [31:0] p, input logic rdy, input logic rspv,
                       input logic [31:0] rspd, input logic redir, input logic [31:0] tgt,
                       input logic ifr);
    pc = p; imem_req_ready = rdy; imem_rsp_valid = rspv; imem_rsp_data = rspd;
    redirect_valid = redir; redirect_target = tgt; if_ready = ifr;
  endtask

  vec_t tbl[21];

  // Random-phase model state.
  logic [31:0] exp_pc, pend_addr, last_pn;
  logic        pend, busy, last_pw, misal;
  int          lat, deliveries;

  initial begin
    reset = 1'b0;
    drive(32'h0, L, L, 32'h0, L, 32'h0, L);

    // Directed cycle table; one row per clock, starting in the IDLE cycle.
    tbl[0]  = mk(32'h0, L, L, 32'h0,         L, 32'h0, L,  L, 32'h0, L, 32'h0, L, 32'h0, 32'h0,         L);
    tbl[1]  = mk(32'h0, H, L, 32'h0,         L, 32'h0, L,  H, 32'h0, L, 32'h0, L, 32'h0, 32'h0,         L);
    tbl[2]  = mk(32'h0, L, H, 32'h00500093,  L, 32'h0, L,  L, 32'h0, H, 32'h4, L, 32'h0, 32'h0,         L);
    for (int i = 3; i <= 7; i++)
      tbl[i] = mk(32'h4, L, L, 32'h0,        L, 32'h0, L,  L, 32'h0, L, 32'h0, H, 32'h0, 32'h00500093,  L);
    tbl[8]  = mk(32'h4, L, L, 32'h0,         L, 32'h0, H,  L, 32'h0, L, 32'h0, H, 32'h0, 32'h00500093,  L);
    tbl[9]  = mk(32'h4, L, L, 32'h0,         L, 32'h0, L,  H, 32'h4, L, 32'h0, L, 32'h0, 32'h00500093,  L);
    tbl[10] = mk(32'h4, H, L, 32'h0,         L, 32'h0, L,  H, 32'h4, L, 32'h0, L, 32'h0, 32'h00500093,  L);
    tbl[11] = mk(32'h4, L, L, 32'h0,         L, 32'h0, L,  L, 32'h0, L, 32'h0, L, 32'h4, 32'h00500093,  L);
    tbl[12] = mk(32'h4, L, H, 32'h00A00113,  L, 32'h0, L,  L, 32'h0, H, 32'h8, L, 32'h4, 32'h00500093,  L);
    tbl[13] = mk(32'h8, L, L, 32'h0,         H, 32'h6, H,  L, 32'h0, H, 32'h6, L, 32'h4, 32'h00A00113,  L);
    tbl[14] = mk(32'h6, L, L, 32'h0,         L, 32'h0, L,  L, 32'h0, L, 32'h0, L, 32'h4, 32'h00A00113,  L);
    tbl[15] = mk(32'h6, L, L, 32'h0,         L, 32'h0, H,  L, 32'h0, L, 32'h0, H, 32'h6, NOP,           H);
    tbl[16] = mk(32'h6, L, L, 32'h0,         H, 32'hFFFFFFFC, L, L, 32'h0, H, 32'hFFFFFFFC, L, 32'h6, NOP, L);
    tbl[17] = mk(32'hFFFFFFFC, H, L, 32'h0,  L, 32'h0, L,  H, 32'hFFFFFFFC, L, 32'h0, L, 32'h6, NOP,   L);
    tbl[18] = mk(32'hFFFFFFFC, L, H, 32'h12345678, L, 32'h0, L, L, 32'h0, H, 32'h0, L, 32'hFFFFFFFC, NOP, L);
    tbl[19] = mk(32'h0, L, L, 32'h0,         L, 32'h0, H,  L, 32'h0, L, 32'h0, H, 32'hFFFFFFFC, 32'h12345678, L);
    tbl[20] = mk(32'h0, L, L, 32'h0,         L, 32'h0, L,  H, 32'h0, L, 32'h0, L, 32'hFFFFFFFC, 32'h12345678, L);

    repeat (2) @(negedge clk);
    check("reset pc_write", pc_write, 0);
    check("reset req_valid", imem_req_valid, 0);
    check("reset if_valid", if_valid, 0);
    check("reset if_fault", if_fault, 0);
    check("reset if_instr", if_instr, 0);
    check("reset if_pc", if_pc, 0);
    check("reset pc_next", pc_next, 0);

    reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].pc, tbl[i].rdy, tbl[i].rspv, tbl[i].rspd, tbl[i].redir, tbl[i].tgt, tbl[i].ifr);
      #1;
      check($sformatf("row%0d req_valid", i), imem_req_valid, tbl[i].e_reqv);
      if (tbl[i].e_reqv) check($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
      check($sformatf("row%0d pc_write", i), pc_write, tbl[i].e_pw);
      if (tbl[i].e_pw) check($sformatf("row%0d pc_next", i), pc_next, tbl[i].e_pn);
      check($sformatf("row%0d if_valid", i), if_valid, tbl[i].e_ifv);
      check($sformatf("row%0d if_pc", i), if_pc, tbl[i].e_ifpc);
      check($sformatf("row%0d if_instr", i), if_instr, tbl[i].e_instr);
      check($sformatf("row%0d if_fault", i), if_fault, tbl[i].e_fault);
      @(negedge clk);
    end

    // Redirect while waiting; the late response must be swallowed.
    drive(32'h0, H, L, 32'h0, L, 32'h0, L); #1;
    check("drop req_valid", imem_req_valid, 1);
    check("drop req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    drive(32'h0, L, L, 32'h0, H, 32'h100, L); #1;
    check("drop redirect pc_write", pc_write, 1);
    check("drop redirect pc_next", pc_next, 32'h100);
    @(negedge clk);
    drive(32'h100, L, L, 32'h0, L, 32'h0, H); #1;
    check("drop idle if_valid", if_valid, 0);
    check("drop idle req_valid", imem_req_valid, 0);
    check("drop idle pc_write", pc_write, 0);
    @(negedge clk);
    drive(32'h100, L, H, 32'hDEADBEEF, L, 32'h0, H); #1;
    check("drop rsp if_valid", if_valid, 0);
    check("drop rsp pc_write", pc_write, 0);
    @(negedge clk);
    drive(32'h100, H, L, 32'h0, L, 32'h0, H); #1;
    check("drop refetch req_valid", imem_req_valid, 1);
    check("drop refetch req_addr", imem_req_addr, 32'h100);
    check("drop refetch if_valid", if_valid, 0);
    @(negedge clk);

    // Reset while waiting, with a stale response straddling reset release.
    reset = 1'b0;
    drive(32'h100, L, H, 32'h00000BAD, L, 32'h0, L); #1;
    check("midreset pc_write", pc_write, 0);
    check("midreset req_valid", imem_req_valid, 0);
    check("midreset if_valid", if_valid, 0);
    check("midreset if_fault", if_fault, 0);
    check("midreset if_instr", if_instr, 0);
    check("midreset if_pc", if_pc, 0);
    check("midreset pc_next", pc_next, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(32'h40, L, H, 32'h00000BAD, L, 32'h0, H); #1;
    check("postreset idle req_valid", imem_req_valid, 0);
    check("postreset idle if_valid", if_valid, 0);
    check("postreset idle pc_write", pc_write, 0);
    @(negedge clk);
    drive(32'h40, L, H, 32'h00000BAD, L, 32'h0, H); #1;
    check("postreset req_valid", imem_req_valid, 1);
    check("postreset req_addr", imem_req_addr, 32'h40);
    check("postreset pc_write", pc_write, 0);
    check("postreset if_valid", if_valid, 0);
    @(negedge clk);
    drive(32'h40, L, L, 32'h0, L, 32'h0, H); #1;
    check("postreset held req_valid", imem_req_valid, 1);
    check("postreset held if_valid", if_valid, 0);
    @(negedge clk);

    // Randomized traffic: the model tracks only which PC the next delivered
    // instruction must carry and what memory holds there.
    reset = 1'b0;
    drive(32'h0, L, L, 32'h0, L, 32'h0, L);
    @(negedge clk);
    reset = 1'b1;
    exp_pc = 32'h0; pend = 1'b0; lat = 0; pend_addr = '0;
    last_pw = 1'b0; last_pn = '0; deliveries = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (last_pw) pc = last_pn;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      busy = pend;
      if (pend) begin
        if (lat == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend = 1'b0;
        end else lat--;
      end
      imem_req_ready = ($urandom_range(0, 2) != 0);
      if_ready       = ($urandom_range(0, 1) != 0);
      redirect_valid = (cyc > 0) && ($urandom_range(0, 7) == 0);
      redirect_target = '0;
      if (redirect_valid) begin
        case ($urandom_range(0, 15))
          0:       redirect_target = 32'hFFFFFFFC;
          1:       redirect_target = {22'h0, 8'($urandom_range(0, 255)), 2'b10};
          default: redirect_target = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        endcase
      end
      #1;
      if (imem_req_valid) begin
        check("rand single outstanding", busy, 0);
        check("rand req_addr", imem_req_addr, exp_pc);
        if (imem_req_ready) begin
          pend = 1'b1;
          lat = $urandom_range(0, 2);
          pend_addr = imem_req_addr;
        end
      end
      if (redirect_valid) begin
        check("rand redirect pc_write", pc_write, 1);
        check("rand redirect pc_next", pc_next, redirect_target);
        check("rand redirect if_valid", if_valid, 0);
        check("rand redirect req_valid", imem_req_valid, 0);
        exp_pc = redirect_target;
      end else begin
        if (pc_write) begin
          check("rand pc_write with response", imem_rsp_valid, 1);
          check("rand pc_next step", pc_next, exp_pc + 32'd4);
        end
        if (if_valid && if_ready) begin
          misal = |exp_pc[1:0];
          check("rand if_pc", if_pc, exp_pc);
          check("rand if_instr", if_instr, misal ? NOP : mem_word(exp_pc));
          check("rand if_fault", if_fault, misal);
          if (!misal) exp_pc = exp_pc + 32'd4;
          deliveries++;
        end
      end
      last_pw = pc_write;
      last_pn = pc_next;
      @(negedge clk);
    end
    check("rand deliveries seen", deliveries > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_STEP, default 4, SHALL be the sequential PC increment in bytes.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, SHALL be the instruction word driven on if_instr for faulted fetches.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-low reset.
REQ-005 pc  input  32  SHALL be the current PC value from the program counter register.
REQ-006 pc_write  output  1  SHALL be the PC update strobe; program counter loads pc_next on the next rising edge.
REQ-007 pc_next  output  32  SHALL be the PC value to load.
REQ-008 imem_req_valid / imem_req_ready  output/input  1/1  SHALL be the instruction-memory request handshake.
REQ-009 imem_req_addr  output  32  SHALL be the fetch address.
REQ-010 imem_rsp_valid / imem_rsp_data  input/input  1/32  SHALL be the response strobe and instruction word; at most one request outstanding.
REQ-011 redirect_valid / redirect_target  input/input  1/32  SHALL be the branch/jump redirect strobe and target.
REQ-012 if_valid / if_ready  output/input  1/1  SHALL be the handshake to decode.
REQ-013 if_instr, if_pc  output  32 each  SHALL be the fetched instruction and its address.
REQ-014 if_fault  output  1  SHALL flag a misaligned fetch.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DROP, OUT.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-017 REQ: imem_req_valid=1 and imem_req_addr=pc when pc[1:0]==0 and redirect_valid=0; on imem_req_ready SHALL capture pc into if_pc and go to WAIT.
REQ-018 REQ with pc[1:0]!=0: no request; if_pc=pc, if_instr=NOP_INSTR, if_fault=1, go to OUT, no pc_write.
REQ-019 WAIT: on imem_rsp_valid, capture imem_rsp_data into if_instr, assert pc_write=1 with pc_next=if_pc+PC_STEP (mod 2^32, 32'hFFFFFFFC wraps to 0) that cycle, go to OUT.
REQ-020 OUT: if_valid=1, if_instr/if_pc/if_fault stable; on if_ready, go to REQ; if_fault clears on leaving OUT.
REQ-021 Redirect (any state except IDLE): pc_write=1, pc_next=redirect_target that cycle, priority over every other pc_write source.
REQ-022 Redirect in REQ: imem_req_valid SHALL be forced 0 that cycle; stay in REQ.
REQ-023 Redirect in WAIT without imem_rsp_valid: go to DROP; DROP discards the next response then goes to REQ.
REQ-024 Redirect in WAIT with imem_rsp_valid same cycle: response discarded, go to REQ.
REQ-025 Redirect in DROP: pc_write with new target; remain in DROP until the pending response arrives.
REQ-026 Redirect in OUT: if_valid SHALL be forced 0 that cycle (no handshake), held instruction killed, go to REQ.
REQ-027 pc_write SHALL be asserted at most one cycle per fetched instruction or redirect.

Reset
REQ-028 Reset assertion SHALL force IDLE immediately; pc_write, imem_req_valid, if_valid, if_fault=0; if_instr, if_pc, pc_next=0.
REQ-029 Reset mid-WAIT SHALL abandon the outstanding request; any response arriving during or after reset before a new request SHALL be ignored.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the state enumeration, NOP_INSTR and PC_STEP defaults.
REQ-031 No sub-module SHALL be required; FSM, capture registers and incrementer reside in instr_fetch.

Verification
REQ-032 pc=0, ready/rsp one cycle later with 32'h00500093 -> pc_write, pc_next=4, if_valid, if_pc=0, if_instr=32'h00500093.
REQ-033 if_ready held 0 for 5 cycles in OUT -> if_valid, if_instr, if_pc stable; no new imem request.
REQ-034 redirect to 32'h100 in WAIT, response 2 cycles later -> response dropped, next request addr=32'h100, no if_valid for dropped word.
REQ-035 pc=32'h6 -> no imem request, if_valid=1, if_fault=1, if_instr=32'h00000013.
REQ-036 pc=32'hFFFFFFFC fetched -> pc_next=0.
REQ-037 reset asserted mid-WAIT, response during reset -> all outputs 0, IDLE one cycle, fresh request on pc.
